// File: rtl/mm_refill_ctrl.sv
// mm_refill_ctrl: fetches the 2-word block around PC on a cache miss and
// delivers it to the instruction cache as one 64-bit fill strobe.
module mm_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 20
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] PC,
    input  logic              HitWrite,
    input  logic              MEM_READY,
    input  logic [31:0]       MEM_RDATA,
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              Access_MM,
    output logic [63:0]       Data_MM,
    output logic [2:0]        index,
    output logic              BUSY,
    output logic [CNT_W-1:0]  CNT_REFILL,
    output logic [CNT_W-1:0]  CNT_STALL
);
    typedef enum logic [2:0] {IDLE, RD0, RD1, FILL, SETTLE} state_t;
    state_t state, next;
    logic [ADDR_W-1:2] blk_pc;
    logic [31:0] word0;
    logic pc_unused;
    assign pc_unused = ^PC[1:0];
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = HitWrite  ? IDLE : RD0;
            RD0:     next = MEM_READY ? RD1  : RD0;
            RD1:     next = MEM_READY ? FILL : RD1;
            FILL:    next = SETTLE;
            default: next = IDLE;
        endcase
        MEM_RD    = (state == RD0) || (state == RD1);
        Access_MM = (state == FILL);
        BUSY      = (state != IDLE);
    end
    // Address and fill line are loaded on the edge entering the state that shows them.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            blk_pc     <= '0;
            word0      <= '0;
            MEM_ADDR   <= '0;
            Data_MM    <= '0;
            index      <= '0;
            CNT_REFILL <= '0;
            CNT_STALL  <= '0;
        end else begin
            if (state == IDLE && !HitWrite) begin
                blk_pc   <= PC[ADDR_W-1:2];
                MEM_ADDR <= {PC[ADDR_W-1:3], 3'b000};
            end
            if (state == RD0 && MEM_READY) begin
                word0    <= MEM_RDATA;
                MEM_ADDR <= {blk_pc[ADDR_W-1:3], 3'b100};
            end
            if (state == RD1 && MEM_READY) begin
                Data_MM <= {MEM_RDATA, word0};
                index   <= blk_pc[4:2];
            end
            if (state == FILL) CNT_REFILL <= CNT_REFILL + CNT_W'(1);
            if (state != IDLE) CNT_STALL  <= CNT_STALL + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mm_refill_ctrl.sv
// tb_mm_refill_ctrl: directed and randomized refills checked against a
// transaction-level model of addresses, fill lines and counter totals.
module tb_mm_refill_ctrl;
    logic        CLK = 0;
    logic        RESET = 1;
    logic [31:0] PC = 0;
    logic        HitWrite = 1;
    logic        MEM_READY = 0;
    logic [31:0] MEM_RDATA = 0;
    logic        MEM_RD;
    logic [31:0] MEM_ADDR;
    logic        Access_MM;
    logic [63:0] Data_MM;
    logic [2:0]  index;
    logic        BUSY;
    logic [19:0] CNT_REFILL;
    logic [19:0] CNT_STALL;

    int n_tests = 0;
    int n_fail = 0;
    int pulses = 0;
    int exp_pulses = 0;
    int exp_refill = 0;
    int exp_stall = 0;

    mm_refill_ctrl dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .HitWrite(HitWrite),
        .MEM_READY(MEM_READY), .MEM_RDATA(MEM_RDATA), .MEM_RD(MEM_RD),
        .MEM_ADDR(MEM_ADDR), .Access_MM(Access_MM), .Data_MM(Data_MM),
        .index(index), .BUSY(BUSY), .CNT_REFILL(CNT_REFILL), .CNT_STALL(CNT_STALL)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) if (Access_MM) pulses++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // One full refill of the block holding pc; pc2 is what PC changes to after the miss is taken.
    task automatic refill(input logic [31:0] pc, input int w0, input int w1,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] pc2);
        logic [31:0] a0, a1;
        a0 = {pc[31:3], 3'b000};
        a1 = {pc[31:3], 3'b100};
        PC = pc;
        HitWrite = 0;
        MEM_READY = 1'($urandom);
        tick;
        PC = pc2;
        for (int i = 0; i <= w0; i++) begin
            HitWrite = 1'($urandom);
            MEM_READY = (i == w0);
            MEM_RDATA = (i == w0) ? d0 : $urandom;
            check("rd0_req", {MEM_RD, BUSY, MEM_ADDR}, {1'b1, 1'b1, a0});
            tick;
        end
        for (int i = 0; i <= w1; i++) begin
            MEM_READY = (i == w1);
            MEM_RDATA = (i == w1) ? d1 : $urandom;
            check("rd1_req", {MEM_RD, Access_MM, MEM_ADDR}, {1'b1, 1'b0, a1});
            tick;
        end
        MEM_READY = 1'($urandom);
        MEM_RDATA = $urandom;
        HitWrite = 1'($urandom);
        check("fill_strobe", {Access_MM, MEM_RD}, 2'b10);
        check("fill_line", Data_MM, {d1, d0});
        check("fill_index", index, pc[4:2]);
        exp_refill++;
        exp_stall += 4 + w0 + w1;
        exp_pulses++;
        tick;
        MEM_READY = 1'($urandom);
        check("settle", {Access_MM, MEM_RD, BUSY, Data_MM}, {1'b0, 1'b0, 1'b1, d1, d0});
        tick;
        check("idle_cnt", {BUSY, CNT_REFILL, CNT_STALL}, {1'b0, 20'(exp_refill), 20'(exp_stall)});
        check("idle_hold", {index, MEM_ADDR, Data_MM}, {pc[4:2], a1, d1, d0});
        check("pulses", 64'(pulses), 64'(exp_pulses));
        HitWrite = 1;
        MEM_READY = 0;
    endtask

    initial begin
        #3;
        check("reset_async", {MEM_RD, Access_MM, BUSY, MEM_ADDR, Data_MM, index, CNT_REFILL, CNT_STALL}, '0);
        tick;
        RESET = 0;
        for (int i = 0; i < 10; i++) begin
            MEM_READY = 1'($urandom);
            tick;
        end
        check("idle_quiet", {MEM_RD, Access_MM, BUSY, CNT_REFILL, CNT_STALL}, '0);
        MEM_READY = 0;

        refill(32'h0000_004C, 0, 0, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_004C);
        refill(32'h0000_1234, 3, 3, 32'h1111_2222, 32'h3333_4444, 32'h0000_1234);
        check("wait_stall", CNT_STALL, 20'd14);
        refill(32'h0000_0100, 1, 0, 32'hDEAD_0000, 32'hBEEF_0004, 32'h0000_0200);
        refill(32'h0000_0200, 0, 2, 32'h0200_0000, 32'h0200_0004, 32'h0000_0200);
        check("back_to_back_refills", CNT_REFILL, 20'd4);

        PC = 32'h0000_0300;
        HitWrite = 0;
        tick;
        MEM_READY = 1;
        MEM_RDATA = 32'h5555_5555;
        tick;
        MEM_READY = 0;
        HitWrite = 1;
        #2 RESET = 1;
        #1;
        check("reset_mid", {MEM_RD, Access_MM, BUSY, MEM_ADDR, Data_MM, index, CNT_REFILL, CNT_STALL}, '0);
        tick;
        RESET = 0;
        exp_refill = 0;
        exp_stall = 0;
        tick;
        tick;
        check("reset_no_fill", {BUSY, Access_MM, 62'(pulses)}, {2'b00, 62'(exp_pulses)});

        for (int n = 0; n < 30; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick;
            refill($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
